// File: rtl/mem_write_checker_if.sv
// Bus bundle for mem_write_checker: table configuration, arm pulse, the
// snooped data-memory store port and the checker status outputs.
interface mem_write_checker_if #(
    parameter int N     = 16,
    parameter int A     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 16
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic          cfg_valid;
    logic [A-1:0]  cfg_addr;
    logic [N-1:0]  cfg_data;
    logic          start;
    logic          memwrite;
    logic [A-1:0]  dataadr;
    logic [N-1:0]  writedata;
    logic          busy;
    logic          pass;
    logic          fail;
    logic [1:0]    fail_code;
    logic [IW-1:0] fail_idx;
    logic [IW:0]   match_count;
    logic [CW-1:0] cycle_count;

    modport master (
        output cfg_we, cfg_idx, cfg_valid, cfg_addr, cfg_data, start,
               memwrite, dataadr, writedata,
        input  busy, pass, fail, fail_code, fail_idx, match_count, cycle_count
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_valid, cfg_addr, cfg_data, start,
               memwrite, dataadr, writedata,
        output busy, pass, fail, fail_code, fail_idx, match_count, cycle_count
    );
endinterface

// File: rtl/mem_write_checker.sv
// Snoops the data-memory store port and checks stores against a small table
// of expected (address, data) pairs, in index order or any order, with a
// cycle timeout. Status is sticky until the checker is re-armed or reset.
module mem_write_checker #(
    parameter int N       = 16,
    parameter int A       = 16,
    parameter int DEPTH   = 4,
    parameter int ORDERED = 1,
    parameter int TIMEOUT = 1000,
    parameter int CW      = 16
) (
    input logic               clk,
    input logic               reset,
    mem_write_checker_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_DATA    = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;
    localparam logic [1:0] FC_ORDER   = 2'b11;

    logic [1:0]       state;
    logic [DEPTH-1:0] tbl_valid;
    logic [A-1:0]     tbl_addr [DEPTH];
    logic [N-1:0]     tbl_data [DEPTH];
    logic [DEPTH-1:0] matched;
    logic [IW-1:0]    ptr;

    logic             busy_q, pass_q, fail_q;
    logic [1:0]       code_q;
    logic [IW-1:0]    idx_q;
    logic [IW:0]      mc_q;
    logic [CW-1:0]    cc_q;

    logic             cfg_ok;
    logic [DEPTH-1:0] arm_valid;
    logic [IW-1:0]    arm_ptr;
    logic [DEPTH-1:0] addr_hit, data_hit, other_hit;
    logic [IW-1:0]    low_addr, low_data, low_other;
    logic             ptr_a, ptr_d;
    logic             do_match, do_fail;
    logic [IW-1:0]    match_idx, fail_at;
    logic [1:0]       fail_kind;
    logic [IW-1:0]    ptr_next;
    logic [IW:0]      valid_count, mc_next;
    logic             complete, timed_out;

    // Table as it will look after this edge's config write, so an arm in the same cycle sees it
    always_comb begin
        cfg_ok    = bus.cfg_we && (state != ST_RUN);
        arm_valid = tbl_valid;
        if (cfg_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.cfg_idx == IW'(i)) arm_valid[i] = bus.cfg_valid;
            end
        end
        arm_ptr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (arm_valid[i]) arm_ptr = IW'(i);
        end
    end

    // Per-entry address/data hits against the snooped store, and the lowest hitting index of each kind
    always_comb begin
        addr_hit  = '0;
        data_hit  = '0;
        other_hit = '0;
        low_addr  = '0;
        low_data  = '0;
        low_other = '0;
        ptr_a     = 1'b0;
        ptr_d     = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            addr_hit[i]  = tbl_valid[i] && !matched[i] && (tbl_addr[i] == bus.dataadr);
            data_hit[i]  = addr_hit[i] && (tbl_data[i] == bus.writedata);
            other_hit[i] = addr_hit[i] && (IW'(i) != ptr);
            if (addr_hit[i])  low_addr  = IW'(i);
            if (data_hit[i])  low_data  = IW'(i);
            if (other_hit[i]) low_other = IW'(i);
            if (IW'(i) == ptr) begin
                ptr_a = addr_hit[i];
                ptr_d = data_hit[i];
            end
        end
    end

    // Classify the store this cycle as a match, a failure, or nothing of interest
    always_comb begin
        do_match  = 1'b0;
        match_idx = ptr;
        do_fail   = 1'b0;
        fail_kind = FC_NONE;
        fail_at   = '0;
        if (state == ST_RUN && bus.memwrite) begin
            if (ORDERED != 0) begin
                if (ptr_d) begin
                    do_match  = 1'b1;
                    match_idx = ptr;
                end else if (ptr_a) begin
                    do_fail   = 1'b1;
                    fail_kind = FC_DATA;
                    fail_at   = ptr;
                end else if (|other_hit) begin
                    do_fail   = 1'b1;
                    fail_kind = FC_ORDER;
                    fail_at   = low_other;
                end
            end else begin
                if (|data_hit) begin
                    do_match  = 1'b1;
                    match_idx = low_data;
                end else if (|addr_hit) begin
                    do_fail   = 1'b1;
                    fail_kind = FC_DATA;
                    fail_at   = low_addr;
                end
            end
        end
    end

    // Next ordered pointer, completion and timeout conditions
    always_comb begin
        ptr_next = ptr;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tbl_valid[i] && (IW'(i) > ptr)) ptr_next = IW'(i);
        end
        valid_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_count = valid_count + (IW+1)'(tbl_valid[i]);
        end
        mc_next   = mc_q + (IW+1)'(do_match);
        complete  = (mc_next == valid_count);
        timed_out = (cc_q == CW'(TIMEOUT - 1));
    end

    // Expectation table: written only outside RUN, wiped by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_addr[i] <= '0;
                tbl_data[i] <= '0;
            end
        end else if (cfg_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.cfg_idx == IW'(i)) begin
                    tbl_valid[i] <= bus.cfg_valid;
                    tbl_addr[i]  <= bus.cfg_addr;
                    tbl_data[i]  <= bus.cfg_data;
                end
            end
        end
    end

    // Checker state machine with its sticky status and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            matched <= '0;
            ptr     <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= FC_NONE;
            idx_q   <= '0;
            mc_q    <= '0;
            cc_q    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cc_q != {CW{1'b1}}) cc_q <= cc_q + CW'(1);
                    if (do_match) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (IW'(i) == match_idx) matched[i] <= 1'b1;
                        end
                        mc_q <= mc_next;
                        ptr  <= ptr_next;
                    end
                    if (complete) begin
                        state  <= ST_PASS;
                        busy_q <= 1'b0;
                        pass_q <= 1'b1;
                    end else if (do_fail) begin
                        state  <= ST_FAIL;
                        busy_q <= 1'b0;
                        fail_q <= 1'b1;
                        code_q <= fail_kind;
                        idx_q  <= fail_at;
                    end else if (timed_out) begin
                        state  <= ST_FAIL;
                        busy_q <= 1'b0;
                        fail_q <= 1'b1;
                        code_q <= FC_TIMEOUT;
                        idx_q  <= '0;
                    end
                end
                default: begin
                    if (bus.start) begin
                        state   <= ST_RUN;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        fail_q  <= 1'b0;
                        code_q  <= FC_NONE;
                        idx_q   <= '0;
                        mc_q    <= '0;
                        cc_q    <= '0;
                        matched <= '0;
                        ptr     <= arm_ptr;
                    end
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;
    assign bus.fail_code   = code_q;
    assign bus.fail_idx    = idx_q;
    assign bus.match_count = mc_q;
    assign bus.cycle_count = cc_q;
endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised successor to the single-check RAM-write test in the computer bench. It snoops the data-memory write port of the MIPS `computer` (`memwrite`, `dataadr`, `writedata`) and compares observed stores against a programmable table of up to `DEPTH` expected (address, data) pairs. Stores can be matched in ordered or unordered mode, with a cycle timeout. It reports sticky pass/fail status, a failure code and counters, so benches and on-board self-test share one checker.

## Interface
- `N`, 16, data width of `writedata` / `cfg_data`
- `A`, 16, address width of `dataadr` / `cfg_addr`
- `DEPTH`, 4, number of expectation-table entries (≥1); index width `IW = $clog2(DEPTH)`, minimum 1
- `ORDERED`, 1, 1 = entries must be matched in index order; 0 = any order
- `TIMEOUT`, 1000, cycles allowed in RUN before timeout failure (≥1)
- `CW`, 16, width of `cycle_count` (must satisfy 2^CW > TIMEOUT)

Ports:
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `cfg_we`  in  1  write one table entry (honoured only in IDLE, PASS, FAIL)
- `cfg_idx`  in  IW  entry index
- `cfg_valid`  in  1  entry-enable bit written with the entry
- `cfg_addr`  in  A  expected store address
- `cfg_data`  in  N  expected store data
- `start`  in  1  pulse: arm checker (honoured in IDLE, PASS, FAIL; ignored in RUN)
- `memwrite`  in  1  snooped store strobe
- `dataadr`  in  A  snooped store address
- `writedata`  in  N  snooped store data
- `busy`  out  1  high in RUN
- `pass`  out  1  sticky: all valid entries matched
- `fail`  out  1  sticky: failure detected
- `fail_code`  out  2  00 none, 01 data mismatch, 10 timeout, 11 order violation
- `fail_idx`  out  IW  entry index associated with the failure (0 for timeout)
- `match_count`  out  IW+1  entries matched so far
- `cycle_count`  out  CW  cycles spent in RUN

## Operation
- FSM states: IDLE, RUN, PASS, FAIL.
- Reset:
  - State goes to IDLE.
  - All table entries are cleared: valid=0, addr=0, data=0.
  - All outputs go to 0.
- `cfg_we` writes entry `cfg_idx` in any state except RUN. In RUN it is dropped silently.
- `start` with no valid entries: go to RUN, then PASS on the next edge.
- `start` otherwise:
  - Go to RUN.
  - Clear per-entry matched flags, `match_count`, `cycle_count`, `fail_code`, `fail_idx`, `pass` and `fail`.
  - Set the ordered pointer `ptr` to the lowest valid index.
- RUN, every cycle: `cycle_count` increments, saturating at 2^CW-1.
- RUN, when `memwrite`=1 and `ORDERED`=1:
  - `dataadr`==entry[ptr].addr and data equal: mark matched; advance `ptr` to the next valid index; `match_count`++.
  - Address equal, data differs: FAIL, code 01, `fail_idx`=ptr.
  - Address equals some other unmatched valid entry's address: FAIL, code 11, `fail_idx`=that entry (lowest index).
  - Any other address is ignored.
- RUN, when `memwrite`=1 and `ORDERED`=0:
  - Candidates are unmatched valid entries whose address equals `dataadr`.
  - If any candidate's data also equals `writedata`, mark the lowest such index matched and `match_count`++.
  - Else if any candidate exists, FAIL, code 01, `fail_idx`=lowest candidate.
  - Stores to addresses of already-matched entries are ignored. Code 11 is never produced.
- Completion: `match_count` equals the number of valid entries → PASS.
- Timeout: `cycle_count`==TIMEOUT-1 in RUN with completion not reached this cycle → FAIL, code 10.
- Priority within one cycle: completion > data mismatch/order violation > timeout.
- PASS and FAIL are sticky. They exit only via `start` (re-arm) or `reset`. `cycle_count` and `match_count` hold their values there.

## Timing
- All outputs are registered. Snooped inputs are sampled at the rising edge `clk`.
- `busy` rises on the first edge after `start` is sampled.
- `pass`/`fail` assert on the edge that samples the deciding store, so they are visible one cycle after the store's cycle. `busy` falls on the same edge.
- `cycle_count`=1 after the first RUN edge. Timeout fail asserts at the TIMEOUT-th RUN edge.
- `reset` asserted mid-RUN forces IDLE and clears the table immediately, without waiting for `clk`.
- `start` and `cfg_we` in the same cycle (outside RUN): the cfg write lands first, and arming uses the updated table.
- `start` and `memwrite` in the same cycle: the store is not checked.

## Test plan
- Ordered pass: DEPTH=4, one entry valid, {addr 64, data 0x0096}; start; store (64, 0x0096) on cycle 5 → `pass`=1, `match_count`=1, `cycle_count`=5, `fail`=0.
- Ordered sequence with violation: entries {10,0x1111},{20,0x2222}; store (20,0x2222) first → `fail`=1, `fail_code`=11, `fail_idx`=1. Re-arm, then store 10 then 20 → `pass`=1, `match_count`=2.
- Data mismatch, unordered: ORDERED=0; entry {64,0x0096}; store (64,0x0095) → `fail_code`=01, `fail_idx`=0. Unrelated store (32,0xFFFF) beforehand → no effect.
- Timeout: TIMEOUT=8, entry {64,0x0096}, no matching store → `fail`=1, `fail_code`=10 exactly 8 edges after start. Final matching store on that same edge → `pass`=1 instead.
- Reset mid-run: start, match 1 of 2 entries, assert `reset` asynchronously → all outputs 0 immediately. After release, `start` → immediate PASS (table cleared, zero valid entries).
- Config lockout: `cfg_we` during RUN changing entry 0's data is ignored. Store matching the original data → `pass`=1.
